// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the neuron_mac stage.
// Helpers work on a wide signed value so callers of any width share them.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_FRAC   = 0;
    localparam int PROD_W     = 2 * DEF_DATA_W;
    localparam int CNT_W      = $clog2(DEF_DATA_W);
    localparam int WIDE_W     = 64;

    // Clamp a wide signed sum into the signed range of an acc_w-bit accumulator.
    function automatic logic signed [WIDE_W-1:0] sat_acc(
        input logic signed [WIDE_W-1:0] sum,
        input int                       acc_w
    );
        logic signed [WIDE_W-1:0] hi_s;
        logic signed [WIDE_W-1:0] lo_s;
        hi_s = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo_s = -(64'sd1 <<< (acc_w - 1));
        if (sum > hi_s) begin
            return hi_s;
        end else if (sum < lo_s) begin
            return lo_s;
        end else begin
            return sum;
        end
    endfunction

    // ReLU, arithmetic right shift by frac, then clamp to the positive data_w range.
    function automatic logic [WIDE_W-1:0] relu_clamp(
        input logic signed [WIDE_W-1:0] acc,
        input int                       frac,
        input int                       data_w
    );
        logic signed [WIDE_W-1:0] shifted_s;
        logic signed [WIDE_W-1:0] max_s;
        shifted_s = acc >>> frac;
        max_s     = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        if (acc <= 64'sd0) begin
            return {WIDE_W{1'b0}};
        end else if (shifted_s > max_s) begin
            return max_s;
        end else begin
            return shifted_s;
        end
    endfunction

endpackage

// File: rtl/neuron_mac_shift_add_mul.sv
// Bit-serial signed multiplier: one multiplier bit per cycle, LSB first,
// with the MSB weighted negatively so the two's-complement product is exact.
module shift_add_mul
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     x,
    input  logic [DATA_W-1:0]     w,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int MUL_W = 2 * DATA_W;
    localparam int CTR_W = $clog2(DATA_W);

    logic [MUL_W-1:0]  mcand_r;
    logic [MUL_W-1:0]  product_r;
    logic [DATA_W-1:0] mplier_r;
    logic [CTR_W-1:0]  cnt_r;
    logic              run_r;
    logic [MUL_W-1:0]  term_s;
    logic              last_bit_s;

    // Shifted partial product and last-bit decode for the current counter value.
    always_comb begin
        term_s     = mcand_r << cnt_r;
        last_bit_s = (cnt_r == CTR_W'(DATA_W - 1));
    end

    // Operand capture on start, then one add (or final subtract) per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= {MUL_W{1'b0}};
            product_r <= {MUL_W{1'b0}};
            mplier_r  <= {DATA_W{1'b0}};
            cnt_r     <= {CTR_W{1'b0}};
            run_r     <= 1'b0;
        end else if (start) begin
            mcand_r   <= {{DATA_W{x[DATA_W-1]}}, x};
            mplier_r  <= w;
            product_r <= {MUL_W{1'b0}};
            cnt_r     <= {CTR_W{1'b0}};
            run_r     <= 1'b1;
        end else if (run_r) begin
            if (mplier_r[cnt_r]) begin
                if (last_bit_s) begin
                    product_r <= product_r - term_s;
                end else begin
                    product_r <= product_r + term_s;
                end
            end
            if (last_bit_s) begin
                run_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CTR_W'(1);
            end
        end
    end

    assign done    = run_r & last_bit_s;
    assign product = product_r;

endmodule

// File: rtl/neuron_mac.sv
// Sequential MAC neuron: serial multiply, saturating accumulate, and on the
// last pair of a vector a ReLU/shift/clamp result offered over valid/ready.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              busy
);

    state_t              state_r;
    logic                last_r;
    logic [ACC_W-1:0]    acc_r;
    logic [DATA_W-1:0]   y_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                start_s;
    logic                mul_done_s;
    logic [2*DATA_W-1:0] product_s;
    logic [ACC_W-1:0]    acc_sat_s;
    logic [DATA_W-1:0]   y_next_s;

    shift_add_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .x       (x),
        .w       (w),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Input handshake, next accumulator value and the formatted output byte.
    always_comb begin
        start_s   = in_ready_r & in_valid;
        acc_sat_s = ACC_W'(sat_acc(WIDE_W'($signed(acc_r)) + WIDE_W'($signed(product_s)), ACC_W));
        y_next_s  = DATA_W'(relu_clamp(WIDE_W'($signed(acc_sat_s)), FRAC, DATA_W));
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            y_r         <= {DATA_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        last_r     <= in_last;
                        state_r    <= ST_MUL;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_sat_s;
                    if (last_r) begin
                        state_r     <= ST_OUT;
                        y_r         <= y_next_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                ST_OUT: begin
                    // The vector is complete once the byte is taken; start a fresh sum.
                    if (out_ready) begin
                        acc_r       <= {ACC_W{1'b0}};
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    acc_r       <= {ACC_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign busy      = busy_r;

endmodule
